sequential_multiplier: RTL and testbench
========================================

// Module: sequential_multiplier
// PURPOSE
//   Signed (two's complement) N x N -> 2N multiplier using iterative Booth recoding.
//   Produces one Booth step per enabled clock and uses a single shared adder.
//   Serves as an area-cheap arithmetic unit in datapaths that can tolerate ~N cycles of latency.
//   Interface is level-triggered: the caller holds start, releases it, then waits a fixed latency.
// PARAMETERS
//   N  32  operand width in bits; product width is 2N. N must be even and >= 4.
// PORTS
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous reset, active-low (0 = reset)
//   start         in   1   level load request; operands sampled every cycle it is high
//   multiplicand  in   N   signed operand M
//   multiplier    in   N   signed operand Q
//   product       out  2N  signed result M*Q, registered
//   en            in   1   clock enable; 0 freezes all state including product
//   Positional port order: clk, start, multiplicand, multiplier, product, reset, en
// BEHAVIOUR
//   Reset (reset==0 at a clk edge): state=IDLE, product=0, all internal registers 0. Reset has priority over en.
//   en==0: no register changes (FSM, counter, accumulator, product all hold).
//   Registers: A (N+1 bits, sign-extended accumulator), Qr (N bits), q_1 (1 bit), Mr (N+1 bits, sign-extended M), cnt.
//   FSM states (with en==1):
//     IDLE : start=1 -> LOAD. Otherwise stay in IDLE.
//     LOAD : each cycle start=1: A=0, Qr=multiplier, q_1=0, Mr=sext(multiplicand), cnt=N.
//            start=0 -> BUSY. Operands are taken from the last cycle start was high.
//     BUSY : per cycle, inspect {Qr[0],q_1}: 01 -> A+=Mr; 10 -> A-=Mr; 00/11 -> no add.
//            Then arithmetic-shift {A,Qr,q_1} right by 1 and decrement cnt.
//            After the step that makes cnt==0: product={A[N-1:0],Qr}, then go to IDLE.
//            start=1 during BUSY aborts the operation (product unchanged) -> LOAD.
//   Latency: product is valid N enabled cycles after the first cycle with start low (32 cycles at N=32).
//   product holds its value until the next completion; it does not change during LOAD or BUSY.
//   Width rule: the (N+1)-bit accumulator makes the most-negative operands exact:
//     (-2^(N-1)) * (-2^(N-1)) = 2^(2N-2), with no overflow. All results are exact in 2N bits.
//   Zero operand on either side yields exactly 0.
//   Reset asserted mid-BUSY: the operation is discarded and product is cleared to 0 on that edge.
// CONFIGURATION
//   SEQ_MULT_RADIX4_EN defined:
//     Radix-4 Booth. Inspect {Qr[1:0],q_1}; add 0, +-Mr or +-2Mr; shift by 2 per step; cnt=N/2.
//     Latency is N/2 cycles. A is N+2 bits.
//   SEQ_MULT_RADIX4_EN undefined: radix-2 as described above, latency N cycles.
//   Results must be bit-identical in both configurations.
// TESTING (N=32, en=1, reset released; start high 3 cycles, low >=40 cycles, then check product)
//   1. M=7,   Q=2          -> product = 64'd14
//   2. M=-7,  Q=3          -> product = -64'd21
//      M=20,  Q=-10        -> product = -64'd200
//      M=-2,  Q=-2         -> product = 64'd4
//   3. M=0,   Q=-60 and M=-80, Q=0 -> product = 64'd0 in both cases
//   4. M=Q=32'h8000_0000   -> product = 64'h4000_0000_0000_0000
//      M=32'h7FFF_FFFF, Q=32'h8000_0000 -> product = 64'hC000_0000_8000_0000
//   5. Control behaviour:
//      en=0 for 10 cycles mid-BUSY -> product delayed by exactly 10 cycles, value still correct.
//      start re-asserted mid-BUSY  -> old result discarded; the new operands' product appears.
//   6. reset=0 mid-BUSY for 1 cycle -> product=0 and FSM returns to IDLE.
//      A following M=-19, Q=3 run -> product = -64'd57.

Source files
------------

// File: rtl/sequential_multiplier.sv
// -----------------------------------------------------------------------------
// sequential_multiplier
//
// Purpose:
//   Signed (two's complement) N x N -> 2N multiplier built around iterative
//   Booth recoding. It retires one Booth step per enabled clock and has a single
//   shared adder. It suits datapaths that can tolerate roughly N cycles of
//   latency in exchange for a small multiplier.
//
//   Handshake is level based. The caller holds start high while it presents the
//   operands, then drops start. The operands used are the ones present on the
//   last cycle that start was high. The product register updates once, when
//   the final Booth step completes. Its value does not change during load or
//   compute.
//
// Configuration:
//   SEQ_MULT_RADIX4_EN  When defined, the multiplier uses radix-4 Booth
//                       recoding: two bits per step and N/2 steps. It uses an
//                       (N+2)-bit accumulator. When undefined (the default),
//                       it uses radix-2 Booth: one bit per step, N steps, and
//                       an (N+1)-bit accumulator. Both configurations give
//                       bit-identical results.
//
// Ports:
//   clk           in   1   rising-edge clock
//   start         in   1   level load request; operands sampled while high
//   multiplicand  in   N   signed operand M
//   multiplier    in   N   signed operand Q
//   product       out  2N  signed registered result M*Q
//   reset         in   1   synchronous reset, active-low
//   en            in   1   clock enable; 0 freezes every register
// -----------------------------------------------------------------------------
module sequential_multiplier #(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  start,
  input  logic signed [N-1:0]   multiplicand,
  input  logic signed [N-1:0]   multiplier,
  output logic signed [2*N-1:0] product,
  input  logic                  reset,
  input  logic                  en
);

`ifdef SEQ_MULT_RADIX4_EN
  localparam int AW    = N + 2;   // room for +-2M partial products
  localparam int STEPS = N / 2;
`else
  localparam int AW    = N + 1;   // one guard bit keeps (-2^(N-1))^2 exact
  localparam int STEPS = N;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

  state_t               state;
  logic signed [AW-1:0] acc;
  logic [N-1:0]         qr;
  logic                 q_1;
  logic signed [N:0]    mr;
  logic [CW-1:0]        cnt;

  logic signed [AW-1:0] mr_ext;
  logic signed [AW-1:0] pp;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_next;
  logic [N-1:0]         qr_next;
  logic                 q_1_next;

  // Booth step: select partial product, add, arithmetic shift of {acc,qr,q_1}
  always_comb begin
    pp       = '0;
`ifdef SEQ_MULT_RADIX4_EN
    mr_ext   = {mr[N], mr};
    unique case ({qr[1:0], q_1})
      3'b001, 3'b010: pp = mr_ext;
      3'b011:         pp = mr_ext <<< 1;
      3'b100:         pp = -(mr_ext <<< 1);
      3'b101, 3'b110: pp = -mr_ext;
      default:        pp = '0;
    endcase
    sum      = acc + pp;
    acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
    qr_next  = {sum[1:0], qr[N-1:2]};
    q_1_next = qr[1];
`else
    mr_ext   = mr;
    unique case ({qr[0], q_1})
      2'b01:   pp = mr_ext;
      2'b10:   pp = -mr_ext;
      default: pp = '0;
    endcase
    sum      = acc + pp;
    acc_next = {sum[AW-1], sum[AW-1:1]};
    qr_next  = {sum[0], qr[N-1:1]};
    q_1_next = qr[0];
`endif
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      qr      <= '0;
      q_1     <= 1'b0;
      mr      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (en) begin
      if (start) begin
        // Any state: (re)load operands. An operation in flight is abandoned
        // and product keeps its previous value.
        acc   <= '0;
        qr    <= multiplier;
        q_1   <= 1'b0;
        mr    <= {multiplicand[N-1], multiplicand};
        cnt   <= CW'(STEPS);
        state <= LOAD;
      end else begin
        unique case (state)
          LOAD: state <= BUSY;
          BUSY: begin
            acc <= acc_next;
            qr  <= qr_next;
            q_1 <= q_1_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              product <= {acc_next[N-1:0], qr_next};
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
module tb_sequential_multiplier;
  localparam int N = 32;
`ifdef SEQ_MULT_RADIX4_EN
  localparam int LAT_EXP = N / 2 + 1;
`else
  localparam int LAT_EXP = N + 1;
`endif

  logic                 clk;
  logic                 start;
  logic signed [N-1:0]  multiplicand;
  logic signed [N-1:0]  multiplier;
  logic signed [2*N-1:0] product;
  logic                 reset;
  logic                 en;

  int total = 0;
  int bad   = 0;

  sequential_multiplier #(.N(N)) dut (
    .clk          (clk),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .reset        (reset),
    .en           (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit signed arithmetic on sign-extended operands.
  function automatic logic signed [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] a;
    logic signed [63:0] b;
    a = {{32{m[31]}}, m};
    b = {{32{q[31]}}, q};
    return a * b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold start for 3 cycles with the given operands, then release it.
  task automatic launch(input logic [31:0] m, input logic [31:0] q);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    repeat (3) cyc();
    start        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    en    = 1'b1;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) cyc();
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL reset_product got=%h want=%h", product, 64'd0);
    end
    reset = 1'b1;
    repeat (45) cyc();
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL idle_product got=%h want=%h", product, 64'd0);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ms [9];
    logic [31:0] qs [9];
    logic [63:0] ex [9];
    ms[0] = 32'd7;          qs[0] = 32'd2;          ex[0] = 64'd14;
    ms[1] = -32'sd7;        qs[1] = 32'd3;          ex[1] = -64'sd21;
    ms[2] = 32'd20;         qs[2] = -32'sd10;       ex[2] = -64'sd200;
    ms[3] = -32'sd2;        qs[3] = -32'sd2;        ex[3] = 64'd4;
    ms[4] = 32'd0;          qs[4] = -32'sd60;       ex[4] = 64'd0;
    ms[5] = -32'sd80;       qs[5] = 32'd0;          ex[5] = 64'd0;
    ms[6] = 32'h8000_0000;  qs[6] = 32'h8000_0000;  ex[6] = 64'h4000_0000_0000_0000;
    ms[7] = 32'h7FFF_FFFF;  qs[7] = 32'h8000_0000;  ex[7] = 64'hC000_0000_8000_0000;
    ms[8] = 32'h7FFF_FFFF;  qs[8] = 32'h7FFF_FFFF;  ex[8] = 64'h3FFF_FFFF_0000_0001;
    for (int i = 0; i < 9; i++) begin
      launch(ms[i], qs[i]);
      repeat (40) cyc();
      total++;
      if (product !== ex[i]) begin
        bad++;
        $display("FAIL directed_%0d m=%h q=%h got=%h want=%h", i, ms[i], qs[i], product, ex[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      m = $urandom;
      q = $urandom;
      if (i % 6 == 1) m = 32'h8000_0000;
      if (i % 6 == 3) q = 32'hFFFF_FFFF;
      if (i % 6 == 5) m = $urandom_range(0, 15);
      e = ref_mul(m, q);
      launch(m, q);
      repeat (40) cyc();
      total++;
      if (product !== e) begin
        bad++;
        $display("FAIL random_%0d m=%h q=%h got=%h want=%h", i, m, q, product, e);
      end
    end
  endtask

  task automatic test_latency();
    logic [63:0] e;
    int lat;
    e = ref_mul(32'd1234567, -32'sd89);
    launch(32'd1234567, -32'sd89);
    lat = 61;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (product === e) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== LAT_EXP) begin
      bad++;
      $display("FAIL latency got=%0d want=%0d", lat, LAT_EXP);
    end
  endtask

  task automatic test_enable_stall();
    logic [63:0] prev;
    logic [63:0] e;
    int lat;
    prev = product;
    e = ref_mul(-32'sd54321, 32'd777);
    launch(-32'sd54321, 32'd777);
    repeat (5) cyc();
    en = 1'b0;
    repeat (10) cyc();
    total++;
    if (product !== prev) begin
      bad++;
      $display("FAIL stall_hold got=%h want=%h", product, prev);
    end
    en = 1'b1;
    lat = 15;
    for (int k = 16; k <= 80; k++) begin
      cyc();
      lat = k;
      if (product === e) break;
      if (k == 80) lat = 81;
    end
    total++;
    if (lat !== LAT_EXP + 10) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=%0d", lat, LAT_EXP + 10);
    end
    total++;
    if (product !== e) begin
      bad++;
      $display("FAIL stall_value got=%h want=%h", product, e);
    end
  endtask

  task automatic test_abort();
    logic [63:0] prev;
    logic [63:0] ea;
    logic [63:0] eb;
    logic        saw_a;
    prev  = product;
    ea    = ref_mul(32'd12345, 32'd678);
    eb    = ref_mul(-32'sd1000, 32'd4321);
    saw_a = 1'b0;
    launch(32'd12345, 32'd678);
    repeat (10) cyc();
    launch(-32'sd1000, 32'd4321);
    total++;
    if (product !== prev) begin
      bad++;
      $display("FAIL abort_hold got=%h want=%h", product, prev);
    end
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (product === ea) saw_a = 1'b1;
    end
    total++;
    if (saw_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_old_result got=%b want=%b", saw_a, 1'b0);
    end
    total++;
    if (product !== eb) begin
      bad++;
      $display("FAIL abort_value got=%h want=%h", product, eb);
    end
  endtask

  task automatic test_reset_mid_busy();
    launch(32'd999, 32'd999);
    repeat (10) cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL midreset_clear got=%h want=%h", product, 64'd0);
    end
    repeat (45) cyc();
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL midreset_idle got=%h want=%h", product, 64'd0);
    end
    launch(-32'sd19, 32'd3);
    repeat (40) cyc();
    total++;
    if (product !== -64'sd57) begin
      bad++;
      $display("FAIL midreset_next got=%h want=%h", product, -64'sd57);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_latency();
    test_enable_stall();
    test_abort();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
